// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, func3 size codes and the
// request legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_DATA, ST_RD, ST_MERGE, ST_WR
    } state_e;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // Unsigned sizes only exist for loads, so a store with BU/HU is illegal.
    function automatic logic is_illegal(input logic we, input logic [2:0] size,
                                        input logic [1:0] a);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = a[0];
            SIZE_W:  bad = |a;
            SIZE_BU: bad = we;
            SIZE_HU: bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load lane select + extension, and store
// merge into the read word (or lane replication + byte enables with LSU_MEM_BE_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
`ifdef LSU_MEM_BE_EN
    ,
    output logic [3:0]  st_be_o
`endif
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            SIZE_B:  ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            SIZE_BU: ld_data_o = {24'h0, shifted[7:0]};
            SIZE_H:  ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            SIZE_HU: ld_data_o = {16'h0, shifted[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

`ifdef LSU_MEM_BE_EN
    always_comb begin
        case (size_i[1:0])
            2'b00: begin
                st_data_o = {4{wdata_i[7:0]}};
                st_be_o   = 4'b0001 << addr_lo_i;
            end
            2'b01: begin
                st_data_o = {2{wdata_i[15:0]}};
                st_be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data_o = wdata_i;
                st_be_o   = 4'b1111;
            end
        endcase
    end
`else
    always_comb begin
        st_data_o = rdata_i;
        case (size_i[1:0])
            2'b00:   st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01:   st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: st_data_o = wdata_i;
        endcase
    end
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit driving a word-wide synchronous data memory. Sub-word stores
// use read-modify-write unless LSU_MEM_BE_EN adds a byte-enable port.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic [29:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef LSU_MEM_BE_EN
    ,
    output logic [3:0]  mem_be
`endif
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rsp_q, rsp_d;
    logic        mis_q, mis_d;
    logic [1:0]  al_addr;
    logic [2:0]  al_size;
    logic [31:0] al_wdata;
    logic [31:0] ld_data, st_data;

`ifdef LSU_MEM_BE_EN
    logic [3:0] be_q, be_d, st_be;

    // Replication happens at accept time, so the aligner sees the raw request in IDLE.
    assign al_addr  = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_size  = (state_q == IDLE) ? req_size : size_q;
    assign al_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
`else
    assign al_addr  = addr_q[1:0];
    assign al_size  = size_q;
    assign al_wdata = wdata_q;
`endif

    lsu_align u_align (
        .addr_lo_i (al_addr),
        .size_i    (al_size),
        .rdata_i   (mem_rdata),
        .wdata_i   (al_wdata),
        .ld_data_o (ld_data),
        .st_data_o (st_data)
`ifdef LSU_MEM_BE_EN
        ,
        .st_be_o   (st_be)
`endif
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
        mis_d   = 1'b0;
`ifdef LSU_MEM_BE_EN
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                size_d  = req_size;
                wdata_d = req_wdata;
                if (is_illegal(req_we, req_size, req_addr[1:0])) begin
                    mis_d = 1'b1;
                end else if (!req_we) begin
                    state_d = LD_RD;
                end else begin
`ifdef LSU_MEM_BE_EN
                    wdata_d = st_data;
                    be_d    = st_be;
                    state_d = ST_WR;
`else
                    state_d = (req_size == SIZE_W) ? ST_WR : ST_RD;
`endif
                end
            end
            LD_RD:   state_d = LD_DATA;
            LD_DATA: begin
                rdata_d = ld_data;
                rsp_d   = 1'b1;
                state_d = IDLE;
            end
            ST_RD:   state_d = ST_MERGE;
            ST_MERGE: begin
                wdata_d = st_data;
                state_d = ST_WR;
            end
            ST_WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
            mis_q   <= 1'b0;
`ifdef LSU_MEM_BE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
            mis_q   <= mis_d;
`ifdef LSU_MEM_BE_EN
            be_q    <= be_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign misalign  = mis_q;
    assign mem_addr  = addr_q[31:2];
    assign mem_re    = (state_q == LD_RD) || (state_q == ST_RD);
    assign mem_we    = (state_q == ST_WR);
    assign mem_wdata = wdata_q;
`ifdef LSU_MEM_BE_EN
    assign mem_be    = mem_we ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small synchronous word memory model.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, misalign, mem_re, mem_we;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [29:0] mem_addr;
`ifdef LSU_MEM_BE_EN
    logic [3:0]  mem_be;
`endif
    logic [31:0] mem [16] = '{4: 32'h8899AABB, default: 32'h0};
    int checks = 0;
    int errs = 0;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign(misalign),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_MEM_BE_EN
        , .mem_be(mem_be)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
        if (mem_we) begin
`ifdef LSU_MEM_BE_EN
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
`else
            mem[mem_addr[3:0]] <= mem_wdata;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    endtask

    task automatic do_load(input string tag, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] exp);
        chk({tag, " ready"}, req_ready, 1);
        issue(1'b0, sz, a, 32'h0);
        step();
        req_valid = 1'b0;
        chk({tag, " mem_re"}, mem_re, 1);
        chk({tag, " mem_addr"}, mem_addr, a >> 2);
        step();
        chk({tag, " rsp early"}, rsp_valid, 0);
        step();
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rdata"}, rsp_rdata, exp);
    endtask

    task automatic do_reject(input string tag, input logic we, input logic [2:0] sz,
                             input logic [31:0] a);
        issue(we, sz, a, 32'h0);
        step();
        req_valid = 1'b0;
        chk({tag, " misalign"}, misalign, 1);
        chk({tag, " ready"}, req_ready, 1);
        chk({tag, " no mem"}, {mem_re, mem_we}, 0);
        step();
        chk({tag, " pulse"}, misalign, 0);
        chk({tag, " no mem2"}, {mem_re, mem_we}, 0);
    endtask

`ifdef LSU_MEM_BE_EN
    task automatic do_store(input string tag, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp, input logic [3:0] be);
        issue(1'b1, sz, a, wd);
        step();
        req_valid = 1'b0;
        chk({tag, " mem_we"}, {mem_re, mem_we}, 2'b01);
        chk({tag, " wdata"}, mem_wdata, exp);
        chk({tag, " be"}, mem_be, be);
        chk({tag, " addr"}, mem_addr, a >> 2);
        step();
        chk({tag, " done"}, {req_ready, mem_we}, 2'b10);
    endtask
`else
    task automatic do_store(input string tag, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp, input logic [3:0] be);
        int wcyc;
        wcyc = (sz == SIZE_W) ? 1 : 3;
        issue(1'b1, sz, a, wd);
        for (int c = 1; c <= wcyc; c++) begin
            step();
            req_valid = 1'b0;
            chk($sformatf("%s re@%0d", tag, c), mem_re, (c == 1 && wcyc == 3) ? 1 : 0);
            chk($sformatf("%s we@%0d", tag, c), mem_we, (c == wcyc) ? 1 : 0);
        end
        chk({tag, " wdata"}, mem_wdata, exp);
        chk({tag, " addr"}, mem_addr, a >> 2);
        chk({tag, " be unused"}, {28'h0, be}, {28'h0, be});
        step();
        chk({tag, " done"}, {req_ready, mem_we}, 2'b10);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ld_sz  [4] = '{SIZE_B, SIZE_BU, SIZE_H, SIZE_HU};
        logic [31:0] ld_a   [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
        logic [31:0] ld_exp [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};

        step(); step();
        chk("rst ready", req_ready, 1);
        chk("rst outs", {rsp_valid, misalign, mem_re, mem_we}, 0);
        chk("rst rdata", rsp_rdata, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst wdata", mem_wdata, 0);
        rst = 1'b1;
        step();

        do_load("LW", SIZE_W, 32'h10, 32'h8899AABB);
        for (int i = 0; i < 4; i++)
            do_load($sformatf("ld%0d", i), ld_sz[i], ld_a[i], ld_exp[i]);

        do_reject("LW12", 1'b0, SIZE_W, 32'h12);
        do_reject("sz011", 1'b0, 3'b011, 32'h10);
        do_reject("SH11", 1'b1, SIZE_H, 32'h11);
        do_reject("SBU", 1'b1, SIZE_BU, 32'h10);

        // rejection immediately followed by an accept at N+1
        issue(1'b0, SIZE_W, 32'h12, 32'h0);
        step();
        chk("b2b misalign", misalign, 1);
        chk("b2b ready", req_ready, 1);
        issue(1'b0, SIZE_W, 32'h10, 32'h0);
        step();
        req_valid = 1'b0;
        chk("b2b re", mem_re, 1);
        chk("b2b mis off", misalign, 0);
        step(); step();
        chk("b2b rsp", {31'h0, rsp_valid}, 1);
        chk("b2b rdata", rsp_rdata, 32'h8899AABB);

        // second request held while the first load is busy
        issue(1'b0, SIZE_BU, 32'h11, 32'h0);
        step();
        issue(1'b0, SIZE_H, 32'h12, 32'h0);
        chk("busy rdy1", req_ready, 0);
        chk("busy re1", mem_re, 1);
        step();
        chk("busy rdy2", req_ready, 0);
        chk("busy re2", mem_re, 0);
        step();
        chk("busy rdy3", req_ready, 1);
        chk("busy rspA", {rsp_valid, rsp_rdata}, {1'b1, 32'h000000AA});
        step();
        req_valid = 1'b0;
        chk("busy reB", mem_re, 1);
        chk("busy rsp off", rsp_valid, 0);
        step(); step();
        chk("busy rspB", {rsp_valid, rsp_rdata}, {1'b1, 32'hFFFF8899});

`ifdef LSU_MEM_BE_EN
        do_store("SB13", SIZE_B, 32'h13, 32'h12345677, 32'h77777777, 4'b1000);
        do_store("SH10", SIZE_H, 32'h10, 32'h0000CAFE, 32'hCAFECAFE, 4'b0011);
`else
        do_store("SB13", SIZE_B, 32'h13, 32'h12345677, 32'h7799AABB, 4'b1000);
        do_store("SH10", SIZE_H, 32'h10, 32'h0000CAFE, 32'h7799CAFE, 4'b0011);
`endif
        do_store("SW14", SIZE_W, 32'h14, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        do_load("LW14", SIZE_W, 32'h14, 32'hDEADBEEF);

        // reset in the middle of an operation
`ifdef LSU_MEM_BE_EN
        issue(1'b0, SIZE_W, 32'h10, 32'h0);
        step();
        req_valid = 1'b0;
`else
        issue(1'b1, SIZE_B, 32'h13, 32'h12345600);
        step();
        req_valid = 1'b0;
        step();
`endif
        rst = 1'b0;
        #1;
        chk("mid ready", req_ready, 1);
        chk("mid outs", {rsp_valid, misalign, mem_re, mem_we}, 0);
        chk("mid rdata", rsp_rdata, 0);
        chk("mid addr", mem_addr, 0);
        chk("mid wdata", mem_wdata, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid quiet%0d", c), {rsp_valid, mem_re, mem_we}, 0);
        end
        rst = 1'b1;
        step();
        chk("post quiet", {rsp_valid, mem_re, mem_we}, 0);
        do_load("LWpost", SIZE_W, 32'h10, 32'h7799CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
